// File: rtl/gf_pkg.sv
// GF(2^m) arithmetic shared by the RS blocks: field constants, multiply, alpha powers
// and the symbol-position-to-locator-root mapping.
package gf_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int T_LEN      = 4;
  localparam int SYMB_NUM   = 1 << SYMB_WIDTH;
  localparam logic [SYMB_WIDTH:0] FIELD_POLY = 9'h11d;

  function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                    input logic [SYMB_WIDTH-1:0] b);
    logic [SYMB_WIDTH-1:0] prod;
    logic [SYMB_WIDTH-1:0] sh;
    prod = '0;
    sh   = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) prod = prod ^ sh;
      if (sh[SYMB_WIDTH-1]) sh = {sh[SYMB_WIDTH-2:0], 1'b0} ^ FIELD_POLY[SYMB_WIDTH-1:0];
      else                  sh = {sh[SYMB_WIDTH-2:0], 1'b0};
    end
    return prod;
  endfunction

  // Square-and-multiply keeps the depth at SYMB_WIDTH multipliers instead of a 2^m table.
  function automatic logic [SYMB_WIDTH-1:0] alpha_to_symb(input logic [SYMB_WIDTH-1:0] e);
    logic [SYMB_WIDTH-1:0] r;
    logic [SYMB_WIDTH-1:0] base;
    r    = SYMB_WIDTH'(1);
    base = SYMB_WIDTH'(2);
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (e[i]) r = gf_mult(r, base);
      base = gf_mult(base, base);
    end
    return r;
  endfunction

  // Position p maps to X = alpha^((p+1) mod (SYMB_NUM-1)), matching the Chien stage ordering.
  function automatic logic [SYMB_WIDTH-1:0] symb_pos_to_x(input logic [SYMB_WIDTH-1:0] p);
    logic [SYMB_WIDTH:0] e;
    e = {1'b0, p} + (SYMB_WIDTH+1)'(1);
    if (e == (SYMB_WIDTH+1)'(SYMB_NUM-1)) e = '0;
    return alpha_to_symb(e[SYMB_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/rs_locator_build_pkg.sv
// Local types and widths for the locator builder.
package rs_locator_build_pkg;
  import gf_pkg::*;

  localparam int LOC_W = SYMB_WIDTH * (T_LEN + 1);
  localparam int POS_W = SYMB_WIDTH * T_LEN;
  localparam int DEG_W = $clog2(T_LEN + 1);
  localparam int K_W   = (T_LEN > 1) ? $clog2(T_LEN) : 1;
  localparam logic [LOC_W-1:0] LOC_ONE = LOC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } loc_state_e;

endpackage

// File: rtl/rs_locator_mac.sv
// One locator update step L' = L * (1 + X*x), truncated to T_LEN+1 coefficients.
// Purely combinational; no latency, no flow control.
module rs_locator_mac
  import gf_pkg::*, rs_locator_build_pkg::*;
(
  input  logic [LOC_W-1:0]      loc_in,
  input  logic [SYMB_WIDTH-1:0] x,
  output logic [LOC_W-1:0]      loc_out
);

  always_comb begin
    loc_out = loc_in;
    for (int j = 1; j <= T_LEN; j++) begin
      loc_out[j*SYMB_WIDTH +: SYMB_WIDTH] = loc_in[j*SYMB_WIDTH +: SYMB_WIDTH] ^
                                            gf_mult(x, loc_in[(j-1)*SYMB_WIDTH +: SYMB_WIDTH]);
    end
  end

endmodule

// File: rtl/rs_locator_build.sv
// Builds the erasure locator prod(1 + X_k*x) one factor per cycle; result pulse T_LEN+1 cycles after accept.
// ready is high only when idle; requests seen while busy are ignored and must be held upstream.
module rs_locator_build
  import gf_pkg::*, rs_locator_build_pkg::*;
(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [POS_W-1:0]      positions,
  input  logic [T_LEN-1:0]      positions_mask,
  input  logic                  positions_vld,
  output logic                  ready,
  output logic [LOC_W-1:0]      locator,
  output logic [DEG_W-1:0]      locator_degree,
  output logic                  locator_vld,
  output logic                  locator_err
);

  loc_state_e          state_q, state_d;
  logic [K_W-1:0]      k_q;
  logic [POS_W-1:0]    pos_q;
  logic [T_LEN-1:0]    mask_q;
  logic [LOC_W-1:0]    acc_q;
  logic [DEG_W-1:0]    deg_acc_q;
  logic                err_acc_q;

  logic [SYMB_WIDTH-1:0] cur_p;
  logic [SYMB_WIDTH-1:0] cur_x;
  logic                  cur_in_range;
  logic                  factor_en;
  logic                  factor_bad;
  logic                  last_k;
  logic [LOC_W-1:0]      mac_out;
  logic [LOC_W-1:0]      acc_next;
  logic [DEG_W-1:0]      deg_next;
  logic                  err_next;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    locator_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (positions_vld) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_k) state_d = ST_DONE;
      end
      ST_DONE: begin
        locator_vld = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_p        = pos_q[k_q*SYMB_WIDTH +: SYMB_WIDTH];
    cur_x        = symb_pos_to_x(cur_p);
    cur_in_range = (cur_p <= SYMB_WIDTH'(SYMB_NUM-2));
    factor_en    = mask_q[k_q] & cur_in_range;
    factor_bad   = mask_q[k_q] & ~cur_in_range;
    last_k       = (k_q == K_W'(T_LEN-1));
    acc_next     = factor_en ? mac_out : acc_q;
    deg_next     = deg_acc_q + DEG_W'(factor_en);
    err_next     = err_acc_q | factor_bad;
  end

  rs_locator_mac u_mac (
    .loc_in  (acc_q),
    .x       (cur_x),
    .loc_out (mac_out)
  );

  // Output registers load on the edge into DONE so they are valid alongside locator_vld.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      k_q            <= '0;
      pos_q          <= '0;
      mask_q         <= '0;
      acc_q          <= LOC_ONE;
      deg_acc_q      <= '0;
      err_acc_q      <= 1'b0;
      locator        <= LOC_ONE;
      locator_degree <= '0;
      locator_err    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (positions_vld) begin
            pos_q     <= positions;
            mask_q    <= positions_mask;
            acc_q     <= LOC_ONE;
            k_q       <= '0;
            deg_acc_q <= '0;
            err_acc_q <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_q     <= acc_next;
          deg_acc_q <= deg_next;
          err_acc_q <= err_next;
          k_q       <= k_q + K_W'(1);
          if (last_k) begin
            locator        <= acc_next;
            locator_degree <= deg_next;
            locator_err    <= err_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_locator_build.sv
// Directed and random-set bench for rs_locator_build with an independent log/antilog locator model.
module tb_rs_locator_build;
  import gf_pkg::*;

  localparam int W  = SYMB_WIDTH;
  localparam int T  = T_LEN;
  localparam int LW = W * (T + 1);

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [W*T-1:0]  positions = '0;
  logic [T-1:0]    positions_mask = '0;
  logic            positions_vld = 1'b0;
  logic            ready;
  logic [LW-1:0]   locator;
  logic [2:0]      locator_degree;
  logic            locator_vld;
  logic            locator_err;

  rs_locator_build dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .positions      (positions),
    .positions_mask (positions_mask),
    .positions_vld  (positions_vld),
    .ready          (ready),
    .locator        (locator),
    .locator_degree (locator_degree),
    .locator_vld    (locator_vld),
    .locator_err    (locator_err)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_tab [0:254];
  int log_tab [0:255];
  int last_acc = 0;

  typedef struct {
    logic [LW-1:0] loc;
    logic [2:0]    deg;
    logic          err;
    int            cyc;
  } exp_s;
  exp_s expq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_tab[(log_tab[a] + log_tab[b]) % 255];
  endfunction

  function automatic logic [W*T-1:0] pk(input int p3, input int p2, input int p1, input int p0);
    return {W'(p3), W'(p2), W'(p1), W'(p0)};
  endfunction

  // Coefficient j of prod(1+X_k x) is the j-th elementary symmetric sum of the X_k.
  function automatic exp_s model(input logic [T-1:0] m, input logic [W*T-1:0] p);
    exp_s r;
    int xs[$];
    int coef [0:T];
    int prod, cnt, pv;
    r.err = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (m[k]) begin
        pv = int'(p[k*W +: W]);
        if (pv > 254) r.err = 1'b1;
        else xs.push_back(exp_tab[(pv + 1) % 255]);
      end
    end
    for (int j = 0; j <= T; j++) coef[j] = 0;
    for (int s = 0; s < (1 << xs.size()); s++) begin
      prod = 1;
      cnt  = 0;
      for (int i = 0; i < xs.size(); i++) begin
        if (((s >> i) & 1) == 1) begin
          prod = gmul(prod, xs[i]);
          cnt++;
        end
      end
      coef[cnt] = coef[cnt] ^ prod;
    end
    for (int j = 0; j <= T; j++) r.loc[j*W +: W] = W'(coef[j]);
    r.deg = 3'(xs.size());
    r.cyc = 0;
    return r;
  endfunction

  function automatic int eval_at(input logic [LW-1:0] loc, input int xv);
    int acc;
    acc = 0;
    for (int j = T; j >= 0; j--) acc = gmul(acc, xv) ^ int'(loc[j*W +: W]);
    return acc;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic req(input logic [T-1:0] m, input logic [W*T-1:0] p, input bit hold);
    exp_s e;
    int t;
    positions      = p;
    positions_mask = m;
    positions_vld  = 1'b1;
    t = 0;
    while (!ready && t < 100) begin
      @(negedge aclk);
      t++;
    end
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: ready=%0b after %0d cycles", ready, t);
    end else begin
      e = model(m, p);
      e.cyc = cyc + T + 1;
      expq.push_back(e);
      last_acc = cyc;
    end
    @(negedge aclk);
    if (!hold) positions_vld = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!locator_vld && t < 100) begin
      @(negedge aclk);
      t++;
    end
    if (!locator_vld) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: locator_vld=%0b after %0d cycles", locator_vld, t);
    end
  endtask

  always @(negedge aclk) begin
    exp_s e;
    if (aresetn && locator_vld) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_vld: locator_vld=1 at cycle %0d, want no pulse", cyc);
      end else begin
        e = expq.pop_front();
        check("model_locator", locator, e.loc);
        check("model_degree", locator_degree, e.deg);
        check("model_err", locator_err, e.err);
        check("model_latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, prev_acc, cnt, pv, xinv, npos;
    bit seen;
    logic [T-1:0] m;
    logic [W*T-1:0] p;
    int used[$];

    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_tab[i] = x;
      log_tab[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11d;
    end

    repeat (3) @(negedge aclk);
    check("rst_ready", ready, 1);
    check("rst_vld", locator_vld, 0);
    check("rst_err", locator_err, 0);
    check("rst_degree", locator_degree, 0);
    check("rst_locator", locator, 64'h01);
    aresetn = 1'b1;
    @(negedge aclk);

    req(4'b0001, pk(0, 0, 0, 0), 0);
    wait_done();
    check("single_locator", locator, 64'h0201);
    check("single_degree", locator_degree, 1);
    check("single_err", locator_err, 0);
    check("single_latency", cyc - last_acc, 5);

    req(4'b0011, pk(0, 0, 1, 0), 0);
    wait_done();
    check("two_locator", locator, 64'h080601);
    check("two_degree", locator_degree, 2);

    req(4'b0001, pk(0, 0, 0, 254), 0);
    wait_done();
    check("wrap_locator", locator, 64'h0101);

    req(4'b0000, pk(7, 9, 11, 13), 0);
    wait_done();
    check("empty_locator", locator, 64'h01);
    check("empty_degree", locator_degree, 0);

    req(4'b0011, pk(0, 0, 0, 255), 0);
    wait_done();
    check("oor_locator", locator, 64'h0201);
    check("oor_degree", locator_degree, 1);
    check("oor_err", locator_err, 1);

    req(4'b0001, pk(0, 0, 0, 3), 0);
    wait_done();
    check("followup_err", locator_err, 0);
    check("followup_locator", locator, 64'h1001);

    req(4'b0001, pk(255, 255, 255, 5), 0);
    wait_done();
    check("unmasked_oor_err", locator_err, 0);
    check("unmasked_oor_locator", locator, 64'h4001);

    req(4'b0011, pk(0, 0, 0, 0), 0);
    wait_done();
    check("dup_locator", locator, 64'h040001);
    check("dup_degree", locator_degree, 2);

    req(4'b1111, pk(200, 17, 254, 1), 0);
    wait_done();

    // Held request: ignored while busy, re-accepted right after the result pulse.
    req(4'b0101, pk(30, 40, 50, 60), 1);
    prev_acc = last_acc;
    for (int i = 0; i < 3; i++) begin
      check("ready_low_in_run", ready, 0);
      @(negedge aclk);
    end
    req(4'b1010, pk(100, 110, 120, 130), 0);
    check("reaccept_gap", last_acc - prev_acc, T + 2);
    wait_done();

    req(4'b0011, pk(0, 0, 8, 9), 0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    expq.delete();
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_vld", locator_vld, 0);
    check("midrst_locator", locator, 64'h01);
    check("midrst_degree", locator_degree, 0);
    check("midrst_err", locator_err, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (locator_vld) seen = 1'b1;
    end
    check("midrst_no_vld", seen, 0);

    // Random distinct position sets: every chosen position must be a root, and nothing else.
    for (int r = 0; r < 8; r++) begin
      m = 4'($urandom_range(1, 15));
      used.delete();
      p = '0;
      for (int k = 0; k < T; k++) begin
        do pv = $urandom_range(0, 254); while (pv inside {used});
        used.push_back(pv);
        p[k*W +: W] = W'(pv);
      end
      req(m, p, 0);
      wait_done();
      npos = 0;
      for (int k = 0; k < T; k++) begin
        if (m[k]) begin
          npos++;
          pv   = int'(p[k*W +: W]);
          xinv = exp_tab[(255 - ((pv + 1) % 255)) % 255];
          check("rt_root", eval_at(locator, xinv), 0);
        end
      end
      cnt = 0;
      for (int q = 0; q < 255; q++) begin
        xinv = exp_tab[(255 - ((q + 1) % 255)) % 255];
        if (eval_at(locator, xinv) == 0) cnt++;
      end
      check("rt_root_count", cnt, npos);
      check("rt_err", locator_err, 0);
    end

    repeat (3) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
